// File: rtl/bpu_update_queue.sv
// bpu_update_queue
// Collects up to two resolved branches per cycle from commit, stores them in
// a circular buffer and replays them in program order to the TAGE predictor
// at one update per cycle. commit_ready_o throttles the commit side.
// Optional feature macro: BPU_UPDATE_PERF_EN enables the three perf counters;
// when undefined the perf ports are tied to zero.
module bpu_update_queue #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned META_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              commit_valid_i,
    input  logic [2*ADDR_WIDTH-1:0] commit_pc_i,
    input  logic [2*META_WIDTH-1:0] commit_meta_i,
    input  logic [1:0]              commit_pred_taken_i,
    input  logic [1:0]              commit_taken_i,
    input  logic [1:0]              commit_is_cond_i,
    output logic                    commit_ready_o,
    output logic                    update_valid_o,
    output logic [ADDR_WIDTH-1:0]   update_pc_o,
    output logic [META_WIDTH-1:0]   update_meta_o,
    output logic                    update_predict_correct_o,
    output logic                    update_branch_taken_o,
    output logic                    update_is_conditional_o,
    output logic [31:0]             perf_update_cnt_o,
    output logic [31:0]             perf_mispredict_cnt_o,
    output logic [31:0]             perf_stall_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [PW:0]           r_count;

    logic [ADDR_WIDTH-1:0] r_pc    [DEPTH];
    logic [META_WIDTH-1:0] r_meta  [DEPTH];
    logic                  r_taken [DEPTH];
    logic                  r_cond  [DEPTH];
    logic                  r_corr  [DEPTH];

    logic                  w_ready;
    logic [1:0]            w_acc;
    logic [1:0]            w_n_enq;
    logic                  w_deq;
    logic [PW-1:0]         w_slot1_idx;

    // Acceptance is all-or-nothing: two free slots are required even for a
    // single commit, so a held producer never sees partial acceptance.
    always_comb begin
        w_ready     = (r_count <= (PW+1)'(DEPTH - 2));
        w_acc       = w_ready ? commit_valid_i : 2'b00;
        w_n_enq     = {1'b0, w_acc[0]} + {1'b0, w_acc[1]};
        w_deq       = (r_count != '0);
        // slot 1 lands right after slot 0, or at wptr when slot 0 is empty
        w_slot1_idx = r_wptr + PW'(w_acc[0]);
    end

    assign commit_ready_o = w_ready;

    // Entry storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (w_acc[0]) begin
            r_pc[r_wptr]    <= commit_pc_i[ADDR_WIDTH-1:0];
            r_meta[r_wptr]  <= commit_meta_i[META_WIDTH-1:0];
            r_taken[r_wptr] <= commit_taken_i[0];
            r_cond[r_wptr]  <= commit_is_cond_i[0];
            r_corr[r_wptr]  <= (commit_pred_taken_i[0] == commit_taken_i[0]);
        end
        if (w_acc[1]) begin
            r_pc[w_slot1_idx]    <= commit_pc_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
            r_meta[w_slot1_idx]  <= commit_meta_i[2*META_WIDTH-1:META_WIDTH];
            r_taken[w_slot1_idx] <= commit_taken_i[1];
            r_cond[w_slot1_idx]  <= commit_is_cond_i[1];
            r_corr[w_slot1_idx]  <= (commit_pred_taken_i[1] == commit_taken_i[1]);
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_n_enq);
            r_rptr  <= r_rptr + PW'(w_deq);
            r_count <= r_count + (PW+1)'(w_n_enq) - (PW+1)'(w_deq);
        end
    end

    // Output register: load the pre-edge head whenever the queue is non-empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_valid_o           <= 1'b0;
            update_pc_o              <= '0;
            update_meta_o            <= '0;
            update_predict_correct_o <= 1'b0;
            update_branch_taken_o    <= 1'b0;
            update_is_conditional_o  <= 1'b0;
        end else begin
            update_valid_o <= w_deq;
            if (w_deq) begin
                update_pc_o              <= r_pc[r_rptr];
                update_meta_o            <= r_meta[r_rptr];
                update_predict_correct_o <= r_corr[r_rptr];
                update_branch_taken_o    <= r_taken[r_rptr];
                update_is_conditional_o  <= r_cond[r_rptr];
            end
        end
    end

`ifdef BPU_UPDATE_PERF_EN
    logic [31:0] r_upd_cnt;
    logic [31:0] r_mis_cnt;
    logic [31:0] r_stall_cnt;

    // Counters step with the dequeue so they match the strobe being presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_cnt   <= '0;
            r_mis_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_deq)
                r_upd_cnt <= r_upd_cnt + 32'd1;
            if (w_deq && r_cond[r_rptr] && !r_corr[r_rptr])
                r_mis_cnt <= r_mis_cnt + 32'd1;
            if ((commit_valid_i != 2'b00) && !w_ready)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_update_cnt_o     = r_upd_cnt;
    assign perf_mispredict_cnt_o = r_mis_cnt;
    assign perf_stall_cnt_o      = r_stall_cnt;
`else
    assign perf_update_cnt_o     = '0;
    assign perf_mispredict_cnt_o = '0;
    assign perf_stall_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_bpu_update_queue.sv
// Testbench for bpu_update_queue: directed scenarios plus randomized commits,
// checked against a queue-based reference model of the update stream.
module tb_bpu_update_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 32;
    localparam int unsigned MW    = 16;

    typedef struct {
        logic [AW-1:0] pc;
        logic [MW-1:0] meta;
        logic          taken;
        logic          cond;
        logic          corr;
    } ent_t;

    logic            clk;
    logic            rst_n;
    logic [1:0]      commit_valid_i;
    logic [2*AW-1:0] commit_pc_i;
    logic [2*MW-1:0] commit_meta_i;
    logic [1:0]      commit_pred_taken_i;
    logic [1:0]      commit_taken_i;
    logic [1:0]      commit_is_cond_i;
    logic            commit_ready_o;
    logic            update_valid_o;
    logic [AW-1:0]   update_pc_o;
    logic [MW-1:0]   update_meta_o;
    logic            update_predict_correct_o;
    logic            update_branch_taken_o;
    logic            update_is_conditional_o;
    logic [31:0]     perf_update_cnt_o;
    logic [31:0]     perf_mispredict_cnt_o;
    logic [31:0]     perf_stall_cnt_o;

    bpu_update_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .META_WIDTH (MW)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .commit_valid_i           (commit_valid_i),
        .commit_pc_i              (commit_pc_i),
        .commit_meta_i            (commit_meta_i),
        .commit_pred_taken_i      (commit_pred_taken_i),
        .commit_taken_i           (commit_taken_i),
        .commit_is_cond_i         (commit_is_cond_i),
        .commit_ready_o           (commit_ready_o),
        .update_valid_o           (update_valid_o),
        .update_pc_o              (update_pc_o),
        .update_meta_o            (update_meta_o),
        .update_predict_correct_o (update_predict_correct_o),
        .update_branch_taken_o    (update_branch_taken_o),
        .update_is_conditional_o  (update_is_conditional_o),
        .perf_update_cnt_o        (perf_update_cnt_o),
        .perf_mispredict_cnt_o    (perf_mispredict_cnt_o),
        .perf_stall_cnt_o         (perf_stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: entries waiting in the queue plus the expected output state.
    ent_t            mq[$];
    logic            e_valid;
    ent_t            e_out;
    int unsigned     m_upd, m_mis, m_stall;
    int unsigned     n_cmp, n_fail;
    int unsigned     n_issued;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        e_valid    = 1'b0;
        e_out.pc   = '0;
        e_out.meta = '0;
        e_out.taken = 1'b0;
        e_out.cond = 1'b0;
        e_out.corr = 1'b0;
        m_upd = 0; m_mis = 0; m_stall = 0;
    endtask

    task automatic check_outputs();
        chk("upd_valid", update_valid_o, e_valid);
        chk("upd_pc", update_pc_o, e_out.pc);
        chk("upd_meta", update_meta_o, e_out.meta);
        chk("upd_taken", update_branch_taken_o, e_out.taken);
        chk("upd_cond", update_is_conditional_o, e_out.cond);
        chk("upd_correct", update_predict_correct_o, e_out.corr);
`ifdef BPU_UPDATE_PERF_EN
        chk("perf_upd", perf_update_cnt_o, m_upd);
        chk("perf_mis", perf_mispredict_cnt_o, m_mis);
        chk("perf_stall", perf_stall_cnt_o, m_stall);
`else
        chk("perf_upd", perf_update_cnt_o, 0);
        chk("perf_mis", perf_mispredict_cnt_o, 0);
        chk("perf_stall", perf_stall_cnt_o, 0);
`endif
    endtask

    // One clock cycle: drive commits, predict the next outputs, check after the edge.
    task automatic step(input logic [1:0] v, input logic [AW-1:0] pc0, input logic [AW-1:0] pc1,
                        input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                        input logic [1:0] pt, input logic [1:0] tk, input logic [1:0] cnd);
        ent_t e;
        logic rdy;
        commit_valid_i      = v;
        commit_pc_i         = {pc1, pc0};
        commit_meta_i       = {m1, m0};
        commit_pred_taken_i = pt;
        commit_taken_i      = tk;
        commit_is_cond_i    = cnd;
        rdy = (mq.size() + 2 <= DEPTH);
        chk("ready", commit_ready_o, rdy);
        if (v != 2'b00 && !rdy) m_stall++;
        if (mq.size() != 0) begin
            e = mq.pop_front();
            e_out   = e;
            e_valid = 1'b1;
            m_upd++;
            n_issued++;
            if (e.cond && !e.corr) m_mis++;
        end else begin
            e_valid = 1'b0;
        end
        if (rdy) begin
            if (v[0]) begin
                e.pc = pc0; e.meta = m0; e.taken = tk[0]; e.cond = cnd[0]; e.corr = (pt[0] == tk[0]);
                mq.push_back(e);
            end
            if (v[1]) begin
                e.pc = pc1; e.meta = m1; e.taken = tk[1]; e.cond = cnd[1]; e.corr = (pt[1] == tk[1]);
                mq.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            step(2'b00, '0, '0, '0, '0, 2'b00, 2'b00, 2'b00);
    endtask

    logic [1:0]    r_v, r_pt, r_tk, r_cd;
    logic [AW-1:0] r_pc0, r_pc1;
    logic [MW-1:0] r_m0, r_m1;
    logic          hold;
    int unsigned   k, guard, issued_before;

    initial begin
        n_cmp = 0; n_fail = 0; n_issued = 0;
        model_reset();
        rst_n = 1'b0;
        commit_valid_i = '0; commit_pc_i = '0; commit_meta_i = '0;
        commit_pred_taken_i = '0; commit_taken_i = '0; commit_is_cond_i = '0;
        #3;
        chk("reset_ready", commit_ready_o, 1'b1);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single commit: mispredicted conditional, visible two cycles later.
        step(2'b01, 32'h1c000100, '0, 16'h1234, '0, 2'b01, 2'b00, 2'b01);
        step(2'b00, '0, '0, '0, '0, 2'b00, 2'b00, 2'b00);
        chk("single_valid", update_valid_o, 1'b1);
        chk("single_pc", update_pc_o, 32'h1c000100);
        chk("single_correct", update_predict_correct_o, 1'b0);
        idle(2);

        // Dual commit: slot 0 leaves first.
        step(2'b11, 32'hA0, 32'hB0, 16'h00A0, 16'h00B0, 2'b11, 2'b01, 2'b11);
        idle(4);

        // Compaction: slot 1 only; ready must stay high throughout.
        step(2'b10, '0, 32'hC0, '0, 16'h00C0, 2'b00, 2'b00, 2'b00);
        idle(3);

        // Backpressure: dual commits every cycle, held while stalled.
        k = 0; guard = 0;
        while (k < 8 && guard < 100) begin
            hold = (mq.size() + 2 > DEPTH);
            step(2'b11, 32'h1000 + 8*k, 32'h1004 + 8*k, MW'(k), MW'(k + 100), 2'b00, 2'b00, 2'b11);
            if (!hold) k++;
            guard++;
        end
        chk("bp_guard", (guard < 100), 1'b1);
        idle(DEPTH + 2);

        // Wrap-around: 20 single commits with ascending pc.
        issued_before = n_issued;
        for (int unsigned i = 0; i < 20; i++)
            step(2'b01, AW'(4*i), '0, MW'(i), '0, 2'b01, 2'b01, 2'b01);
        idle(4);
        chk("wrap_issued", n_issued - issued_before, 20);

        // Reset mid-operation with five entries pending.
        for (int unsigned i = 0; i < 4; i++)
            step(2'b11, 32'h2000 + 8*i, 32'h2004 + 8*i, '0, '0, 2'b00, 2'b00, 2'b11);
        chk("pre_reset_depth", mq.size(), 5);
        commit_valid_i = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midreset_ready", commit_ready_o, 1'b1);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // Randomized commits with a producer that holds while stalled.
        hold = 1'b0;
        r_v = '0; r_pt = '0; r_tk = '0; r_cd = '0; r_pc0 = '0; r_pc1 = '0; r_m0 = '0; r_m1 = '0;
        for (int unsigned i = 0; i < 400; i++) begin
            if (!hold) begin
                r_v   = 2'($urandom_range(0, 3));
                r_pc0 = $urandom; r_pc1 = $urandom;
                r_m0  = MW'($urandom); r_m1 = MW'($urandom);
                r_pt  = 2'($urandom); r_tk = 2'($urandom); r_cd = 2'($urandom);
            end
            hold = (r_v != 2'b00) && (mq.size() + 2 > DEPTH);
            step(r_v, r_pc0, r_pc1, r_m0, r_m1, r_pt, r_tk, r_cd);
        end
        idle(DEPTH + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
